combo_sender: RTL and testbench

- Transmit side of the combination-lock digit-entry interface. It drives a 4-bit switch bus and an active-low push-button strobe so that a lock-style receiver sees a sequence of digit entries.
- Each entry is a stable digit followed by a press and release. Timing is slow enough for a receiver that samples the button through a divided clock (count[15] of CLOCK_50) and a two-flop edge detector.
- Used for automated lock entry, bench stimulus and board self-test.

---
 rtl/combo_sender.sv | 144 ++++++++++++++
 tb/tb_combo_sender.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/combo_sender.sv
// Transmit side of a combination-lock entry interface: presents each digit on
// SW_OUT, then strobes PB_N low and releases it with lock-friendly slow timing.
module combo_sender #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned SETUP_CYCLES = 131072,
    parameter int unsigned PRESS_CYCLES = 262144,
    parameter int unsigned GAP_CYCLES   = 262144,
    parameter int unsigned CNT_W        = 20,
    localparam int unsigned IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int unsigned CODE_W      = DIGITS * DIGIT_W
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic [CODE_W-1:0]  CODE,
    output logic [DIGIT_W-1:0] SW_OUT,
    output logic               PB_N,
    output logic               BUSY,
    output logic               DONE,
    output logic [IDX_W-1:0]   DIGIT_IDX
);

    localparam logic [CNT_W-1:0] SETUP_T  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESS_T  = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_T    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PRESS,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CODE_W-1:0]  shreg_q, shreg_d;
    logic [DIGIT_W-1:0] sw_q, sw_d;
    logic               pb_n_q, pb_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               abort_q, abort_d;
    logic [CODE_W-1:0]  shifted_c;

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        shreg_d   = shreg_q;
        sw_d      = sw_q;
        pb_n_d    = pb_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        idx_d     = idx_q;
        abort_d   = abort_q;
        shifted_c = shreg_q >> DIGIT_W;

        if (state_q == S_IDLE) begin
            // ABORT outranks START so a simultaneous request sends nothing
            if (START && !ABORT) begin
                shreg_d = CODE;
                sw_d    = CODE[DIGIT_W-1:0];
                idx_d   = '0;
                busy_d  = 1'b1;
                pb_n_d  = 1'b1;
                timer_d = SETUP_T;
                state_d = S_SETUP;
            end
        end else if (ABORT && !abort_q) begin
            // Cancel: force a full release gap so the receiver sees a clean edge
            pb_n_d  = 1'b1;
            timer_d = GAP_T;
            abort_d = 1'b1;
            state_d = S_GAP;
        end else if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
        end else begin
            case (state_q)
                S_SETUP: begin
                    pb_n_d  = 1'b0;
                    timer_d = PRESS_T;
                    state_d = S_PRESS;
                end
                S_PRESS: begin
                    pb_n_d  = 1'b1;
                    timer_d = GAP_T;
                    state_d = S_GAP;
                end
                default: begin
                    if (abort_q || idx_q == LAST_IDX) begin
                        done_d  = !abort_q;
                        busy_d  = 1'b0;
                        sw_d    = '0;
                        idx_d   = '0;
                        abort_d = 1'b0;
                        pb_n_d  = 1'b1;
                        timer_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        shreg_d = shifted_c;
                        sw_d    = shifted_c[DIGIT_W-1:0];
                        idx_d   = idx_q + IDX_W'(1);
                        timer_d = SETUP_T;
                        state_d = S_SETUP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            shreg_q <= '0;
            sw_q    <= '0;
            pb_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            shreg_q <= shreg_d;
            sw_q    <= sw_d;
            pb_n_q  <= pb_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            abort_q <= abort_d;
        end
    end

    assign SW_OUT    = sw_q;
    assign PB_N      = pb_n_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DIGIT_IDX = idx_q;

endmodule

// File: tb/tb_combo_sender.sv
// Bench for combo_sender: per-cycle compare against a timeline model of the
// transmission, plus literal pins on sequence, BUSY length and DONE count.
module tb_combo_sender;

    localparam int SETUP = 2;
    localparam int PRESS = 3;
    localparam int GAP   = 4;
    localparam int NDIG  = 4;
    localparam int SLOT  = SETUP + PRESS + GAP;
    localparam int TOTAL = NDIG * SLOT;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N;
    logic        START;
    logic        ABORT;
    logic [15:0] CODE;
    logic [3:0]  SW_OUT;
    logic        PB_N;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  DIGIT_IDX;

    combo_sender #(
        .DIGITS(4), .DIGIT_W(4), .SETUP_CYCLES(SETUP), .PRESS_CYCLES(PRESS),
        .GAP_CYCLES(GAP), .CNT_W(20)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .CODE(CODE), .SW_OUT(SW_OUT), .PB_N(PB_N), .BUSY(BUSY), .DONE(DONE),
        .DIGIT_IDX(DIGIT_IDX)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int tests = 0;
    int fails = 0;

    // Model: mode 0 idle, 1 sending (m_off = cycle offset since BUSY rose), 2 abort gap
    int          m_mode;
    int          m_off;
    logic [15:0] m_code;
    int          m_left;
    int          m_absw;
    int          m_abidx;
    bit          m_done;

    int busy_cnt;
    int done_cnt;
    int falls[$];
    logic prev_pb;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_sw();
        if (m_mode == 1) return int'((m_code >> (4 * (m_off / SLOT))) & 16'hF);
        if (m_mode == 2) return m_absw;
        return 0;
    endfunction

    function automatic int exp_pb();
        int ph;
        if (m_mode != 1) return 1;
        ph = m_off % SLOT;
        return (ph >= SETUP && ph < SETUP + PRESS) ? 0 : 1;
    endfunction

    function automatic int exp_idx();
        if (m_mode == 1) return m_off / SLOT;
        if (m_mode == 2) return m_abidx;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_off = 0; m_code = '0; m_left = 0;
        m_absw = 0; m_abidx = 0; m_done = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input logic [15:0] c);
        m_done = 0;
        case (m_mode)
            0: if (s && !a) begin
                m_mode = 1; m_off = 0; m_code = c;
            end
            1: if (a) begin
                m_absw = exp_sw(); m_abidx = exp_idx();
                m_mode = 2; m_left = GAP;
            end else begin
                m_off++;
                if (m_off == TOTAL) begin
                    m_mode = 0; m_done = 1;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("sw_out", int'(SW_OUT), exp_sw());
        chk("pb_n", int'(PB_N), exp_pb());
        chk("busy", int'(BUSY), (m_mode != 0) ? 1 : 0);
        chk("done", int'(DONE), m_done ? 1 : 0);
        chk("digit_idx", int'(DIGIT_IDX), exp_idx());
        if (BUSY) busy_cnt++;
        if (DONE) done_cnt++;
        if (prev_pb && !PB_N) falls.push_back(int'(SW_OUT));
        prev_pb = PB_N;
    endtask

    // One clock: check current outputs, drive inputs for the next edge, advance model
    task automatic cycle(input bit s, input bit a, input logic [15:0] c);
        check_outputs();
        START = s; ABORT = a; CODE = c;
        model_step(s, a, c);
        @(negedge CLOCK_50);
    endtask

    task automatic reset_pulse();
        check_outputs();
        START = 1'b0; ABORT = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_sw", int'(SW_OUT), 0);
        chk("async_rst_pb", int'(PB_N), 1);
        chk("async_rst_busy", int'(BUSY), 0);
        chk("async_rst_done", int'(DONE), 0);
        #1 RESET_N = 1'b1;
        model_reset();
        prev_pb = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic clear_stats();
        busy_cnt = 0; done_cnt = 0; falls.delete();
    endtask

    task automatic chk_seq(input string name, input int n);
        int exp_d[4];
        exp_d = '{1, 2, 4, 8};
        chk({name, "_count"}, falls.size(), n);
        for (int i = 0; i < n && i < falls.size(); i++)
            chk(name, falls[i], exp_d[i]);
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0; CODE = '0;
        prev_pb = 1'b1;
        model_reset();
        clear_stats();
        repeat (2) @(negedge CLOCK_50);
        chk("reset_sw", int'(SW_OUT), 0);
        chk("reset_pb", int'(PB_N), 1);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_idx", int'(DIGIT_IDX), 0);
        RESET_N = 1'b1;

        // Idle with ABORT poked once: nothing should happen
        for (int i = 0; i < 10; i++) cycle(1'b0, (i == 4), 16'h0);
        cycle(1'b1, 1'b1, 16'h8421);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0);
        chk("idle_busy_cnt", busy_cnt, 0);
        chk("idle_done_cnt", done_cnt, 0);

        // Full transmission with START re-pulsed at cycles 5 and 20
        clear_stats();
        cycle(1'b1, 1'b0, 16'h8421);
        for (int i = 0; i < 45; i++) cycle((i == 5 || i == 20), 1'b0, 16'hFFFF);
        chk("tx_busy_len", busy_cnt, 36);
        chk("tx_done_cnt", done_cnt, 1);
        chk_seq("tx_digit", 4);

        // ABORT in the PRESS of digit 2 (offset 21)
        clear_stats();
        cycle(1'b1, 1'b0, 16'h8421);
        for (int i = 0; i < 21; i++) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0);
        chk("abort_pb_next", int'(PB_N), 1);
        for (int i = 0; i < 8; i++) cycle(1'b0, (i == 1), 16'h0);
        chk("abort_busy_len", busy_cnt, 26);
        chk("abort_done_cnt", done_cnt, 0);
        chk_seq("abort_digit", 3);

        clear_stats();
        cycle(1'b1, 1'b0, 16'h8421);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 16'h0);
        chk("restart_done_cnt", done_cnt, 1);
        chk_seq("restart_digit", 4);

        // Asynchronous reset during PRESS of digit 0
        clear_stats();
        cycle(1'b1, 1'b0, 16'h8421);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0);
        reset_pulse();
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 16'h0);
        chk("rst_done_cnt", done_cnt, 0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) reset_pulse();
            else cycle(($urandom_range(0, 14) == 0), ($urandom_range(0, 59) == 0),
                       16'($urandom()));
        end
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
